// File: rtl/trade_dispatch_scheduler_pkg.sv
// Shared types for the tick dispatch scheduler: tick layout, FSM states, counter widths.
package trade_sched_pkg;

    localparam int STOCK_ID_W = 2;
    localparam int PRICE_W    = 14;
    localparam int TICK_W     = STOCK_ID_W + PRICE_W;
    localparam int DROP_W     = 8;

    typedef struct packed {
        logic [STOCK_ID_W-1:0] id;
        logic [PRICE_W-1:0]    price;
    } tick_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } sched_state_e;

endpackage

// File: rtl/trade_dispatch_scheduler_if.sv
// Tick-feed and engine-side signals of the dispatch scheduler; slave = scheduler, master = its environment.
interface trade_dispatch_scheduler_if;
    import trade_sched_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [TICK_W-1:0] in_data;
    logic              eng_enable;
    logic [TICK_W-1:0] eng_data;
    logic              eng_done;
    logic              busy;
    logic [3:0]        pending;
    logic              timeout_err;
    logic [DROP_W-1:0] drop_cnt;

    modport slave (
        input  in_valid, in_data, eng_done,
        output in_ready, eng_enable, eng_data, busy, pending, timeout_err, drop_cnt
    );

    modport master (
        output in_valid, in_data, eng_done,
        input  in_ready, eng_enable, eng_data, busy, pending, timeout_err, drop_cnt
    );

endinterface

// File: rtl/trade_dispatch_scheduler_rr_arbiter4.sv
// Combinational 4-way round-robin pick: first requester strictly after ptr, wrapping.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld
);

    logic [1:0] cand;

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        // i == 4 wraps back onto ptr itself, so the last grantee is considered last.
        for (int i = 1; i <= 4; i++) begin
            cand = ptr + 2'(i);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/trade_dispatch_scheduler.sv
// Round-robin dispatcher of latest-per-stock ticks to one shared trading engine.
// Optional SCHED_STATS_EN builds the saturating overwrite (drop) counter.
module trade_dispatch_scheduler #(
    parameter int PRICE_W  = 14,
    parameter int N_STOCKS = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    trade_dispatch_scheduler_if.slave  bus
);
    import trade_sched_pkg::*;

    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    sched_state_e          state_q, state_d;
    tick_t                 slot_q [N_STOCKS];
    logic [N_STOCKS-1:0]   pending_q, pending_d;
    logic [1:0]            rr_ptr_q, rr_ptr_d;
    logic                  eng_enable_q, eng_enable_d;
    tick_t                 eng_data_q, eng_data_d;
    logic                  timeout_err_q, timeout_err_d;
    logic [WCNT_W-1:0]     wait_cnt_q, wait_cnt_d;

    logic                  cap_vld;
    logic [STOCK_ID_W-1:0] cap_id;
    logic [1:0]            gnt_idx;
    logic                  gnt_vld;
    logic                  grant_fire;

    assign bus.in_ready = ~rst;
    // A zero price is a malformed quote: handshake completes but nothing is stored.
    assign cap_vld    = bus.in_valid && bus.in_ready && (bus.in_data[PRICE_W-1:0] != '0);
    assign cap_id     = bus.in_data[PRICE_W +: STOCK_ID_W];
    assign grant_fire = (state_q == IDLE) && gnt_vld;

    rr_arbiter4 u_arb (
        .req     (pending_q),
        .ptr     (rr_ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        rr_ptr_d      = rr_ptr_q;
        eng_enable_d  = 1'b0;
        eng_data_d    = eng_data_q;
        timeout_err_d = timeout_err_q;
        wait_cnt_d    = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_fire) begin
                    eng_data_d         = slot_q[gnt_idx];
                    eng_enable_d       = 1'b1;
                    pending_d[gnt_idx] = 1'b0;
                    rr_ptr_d           = gnt_idx;
                    wait_cnt_d         = '0;
                    state_d            = WAIT;
                end
            end
            WAIT: begin
                if (bus.eng_done) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Applied after the grant clear so a same-edge write leaves the slot pending.
        if (cap_vld) pending_d[cap_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            rr_ptr_q      <= 2'd3;
            eng_enable_q  <= 1'b0;
            eng_data_q    <= '0;
            timeout_err_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            rr_ptr_q      <= rr_ptr_d;
            eng_enable_q  <= eng_enable_d;
            eng_data_q    <= eng_data_d;
            timeout_err_q <= timeout_err_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_STOCKS; i++) slot_q[i] <= '0;
        end else if (cap_vld) begin
            slot_q[cap_id] <= tick_t'(bus.in_data);
        end
    end

`ifdef SCHED_STATS_EN
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
    logic              drop_evt;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == '1) ? v : v + DROP_W'(1);
    endfunction

    // Writing the slot being granted this edge replaces nothing still waiting, so no drop.
    assign drop_evt = cap_vld && pending_q[cap_id] && !(grant_fire && (gnt_idx == cap_id));

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_evt) drop_cnt_d = sat_inc(drop_cnt_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign bus.drop_cnt = drop_cnt_q;
`else
    assign bus.drop_cnt = '0;
`endif

    assign bus.eng_enable  = eng_enable_q;
    assign bus.eng_data    = eng_data_q;
    assign bus.busy        = (state_q == WAIT);
    assign bus.pending     = pending_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_trade_dispatch_scheduler.sv
// Directed bench for trade_dispatch_scheduler with a dispatch-order scoreboard.
module tb_trade_dispatch_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    trade_dispatch_scheduler_if bus ();

    trade_dispatch_scheduler #(
        .PRICE_W  (14),
        .N_STOCKS (4),
        .TIMEOUT  (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

`ifdef SCHED_STATS_EN
    localparam int DROP_ONE = 1;
    localparam int DROP_SAT = 255;
`else
    localparam int DROP_ONE = 0;
    localparam int DROP_SAT = 0;
`endif

    int          vecs = 0;
    int          errs = 0;
    logic [15:0] exp_q [$];
    bit          sb_en = 1'b1;
    int          cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic done_pulse();
        @(negedge clk);
        bus.eng_done = 1'b1;
        @(negedge clk);
        bus.eng_done = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_in_ready"},    {31'd0, bus.in_ready},    32'd0);
        check({pfx, "_eng_enable"},  {31'd0, bus.eng_enable},  32'd0);
        check({pfx, "_eng_data"},    {16'd0, bus.eng_data},    32'd0);
        check({pfx, "_busy"},        {31'd0, bus.busy},        32'd0);
        check({pfx, "_pending"},     {28'd0, bus.pending},     32'd0);
        check({pfx, "_timeout_err"}, {31'd0, bus.timeout_err}, 32'd0);
        check({pfx, "_drop_cnt"},    {24'd0, bus.drop_cnt},    32'd0);
    endtask

    // Scoreboard: every dispatch strobe must match the next predicted tick.
    always @(posedge clk) begin
        #1;
        if (!rst && sb_en && bus.eng_enable) begin
            vecs++;
            assert (exp_q.size() != 0) else begin
                errs++;
                $error("FAIL unexpected_dispatch: observed %0h expected none", bus.eng_data);
            end
            if (exp_q.size() != 0) check("dispatch_data", {16'd0, bus.eng_data}, {16'd0, exp_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.eng_done = 1'b0;
        step(); step();
        check_reset_vals("reset");
        rst = 1'b0;
        step();
        check("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

        // single tick, done after 3 cycles
        exp_q.push_back(16'h4064);
        bus.in_valid = 1'b1; bus.in_data = 16'h4064;
        step();
        bus.in_valid = 1'b0;
        check("t1_pending_after_capture", {28'd0, bus.pending}, 32'h2);
        check("t1_no_enable_yet", {31'd0, bus.eng_enable}, 32'd0);
        step();
        check("t1_enable", {31'd0, bus.eng_enable}, 32'd1);
        check("t1_busy", {31'd0, bus.busy}, 32'd1);
        check("t1_pending_cleared", {28'd0, bus.pending}, 32'd0);
        step();
        check("t1_enable_one_cycle", {31'd0, bus.eng_enable}, 32'd0);
        check("t1_data_held", {16'd0, bus.eng_data}, 32'h4064);
        step();
        bus.eng_done = 1'b1;
        step();
        bus.eng_done = 1'b0;
        check("t1_idle_after_done", {31'd0, bus.busy}, 32'd0);
        check("t1_pending_zero", {28'd0, bus.pending}, 32'd0);

        // fairness burst with immediate done, id0 refilled mid-sequence
        exp_q.push_back(16'h0011); exp_q.push_back(16'h4022);
        exp_q.push_back(16'h8033); exp_q.push_back(16'hC044);
        exp_q.push_back(16'h0055);
        bus.eng_done = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 16'h0011;
        step(); bus.in_data = 16'h4022;
        step(); bus.in_data = 16'h8033;
        step(); bus.in_data = 16'hC044;
        step(); bus.in_data = 16'h0055;
        step(); bus.in_valid = 1'b0;
        repeat (10) step();
        bus.eng_done = 1'b0;
        step();
        check("t2_all_served", exp_q.size(), 32'd0);
        check("t2_pending_zero", {28'd0, bus.pending}, 32'd0);
        check("t2_idle", {31'd0, bus.busy}, 32'd0);

        // overwrite while engine busy: only the latest id2 tick goes out
        exp_q.push_back(16'h4001); exp_q.push_back(16'h803C);
        bus.in_valid = 1'b1; bus.in_data = 16'h4001;
        step(); bus.in_data = 16'h8032;
        step(); bus.in_data = 16'h803C;
        step(); bus.in_valid = 1'b0;
        check("t3_pending_id2", {28'd0, bus.pending}, 32'h4);
        check("t3_drop_one", {24'd0, bus.drop_cnt}, DROP_ONE);
        done_pulse();
        done_pulse();
        step();
        check("t3_overwrite_served", exp_q.size(), 32'd0);

        // write to id0 on the edge id0 is granted; then zero-price quotes
        exp_q.push_back(16'h0011); exp_q.push_back(16'h0022);
        bus.in_valid = 1'b1; bus.in_data = 16'h0011;
        step(); bus.in_data = 16'h0022;
        step(); bus.in_valid = 1'b0;
        check("t5_old_data_out", {16'd0, bus.eng_data}, 32'h0011);
        check("t5_pending_kept", {28'd0, bus.pending}, 32'h1);
        check("t5_drop_unchanged", {24'd0, bus.drop_cnt}, DROP_ONE);
        done_pulse();
        done_pulse();
        step();
        check("t5_new_data_served", exp_q.size(), 32'd0);
        bus.in_valid = 1'b1; bus.in_data = 16'h0000;
        check("t5_zero_price_ready", {31'd0, bus.in_ready}, 32'd1);
        step(); bus.in_data = 16'h4000;
        step(); bus.in_valid = 1'b0;
        repeat (3) step();
        check("t5_zero_price_not_pending", {28'd0, bus.pending}, 32'd0);
        check("t5_zero_price_no_dispatch", {31'd0, bus.busy}, 32'd0);
        check("t5_drop_after_zero", {24'd0, bus.drop_cnt}, DROP_ONE);

        // timeout: engine never answers
        exp_q.push_back(16'hC0AA); exp_q.push_back(16'h00BB);
        bus.in_valid = 1'b1; bus.in_data = 16'hC0AA;
        step(); bus.in_data = 16'h00BB;
        step(); bus.in_valid = 1'b0;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 40) begin
            cnt++;
            step();
        end
        check("t4_wait_cycles", cnt, 32'd15);
        check("t4_timeout_err", {31'd0, bus.timeout_err}, 32'd1);
        step();
        check("t4_next_dispatched", {31'd0, bus.eng_enable}, 32'd1);
        done_pulse();
        step();
        check("t4_timeout_sticky", {31'd0, bus.timeout_err}, 32'd1);
        check("t4_served", exp_q.size(), 32'd0);

        // 300 overwrites saturate the drop counter
        sb_en = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            bus.in_valid = 1'b1;
            bus.in_data  = {2'b11, 14'(i + 1)};
        end
        step();
        bus.in_valid = 1'b0;
        check("t3_drop_saturated", {24'd0, bus.drop_cnt}, DROP_SAT);
        bus.eng_done = 1'b1;
        repeat (20) step();
        bus.eng_done = 1'b0;
        step();
        check("t3_flood_drained", {28'd0, bus.pending}, 32'd0);
        sb_en = 1'b1;

        // asynchronous reset in the middle of WAIT
        exp_q.push_back(16'h4077);
        bus.in_valid = 1'b1; bus.in_data = 16'h4077;
        step(); bus.in_data = 16'hC011;
        step(); bus.in_data = 16'h8011;
        step(); bus.in_valid = 1'b0;
        check("t6_busy_before_reset", {31'd0, bus.busy}, 32'd1);
        #2 rst = 1'b1;
        #1 check_reset_vals("t6_async");
        step();
        rst = 1'b0;
        exp_q.push_back(16'h8099); exp_q.push_back(16'h0099); exp_q.push_back(16'h4099);
        bus.in_valid = 1'b1; bus.in_data = 16'h8099;
        step(); bus.in_data = 16'h0099;
        step(); bus.in_data = 16'h4099;
        step(); bus.in_valid = 1'b0;
        check("t6_pending_after_refill", {28'd0, bus.pending}, 32'h3);
        done_pulse();
        done_pulse();
        done_pulse();
        repeat (3) step();
        check("t6_all_served", exp_q.size(), 32'd0);
        check("t6_pending_zero", {28'd0, bus.pending}, 32'd0);
        check("t6_idle", {31'd0, bus.busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
